muldiv_unit: RTL and testbench

Iterative 16-bit multiply/divide unit sitting directly downstream of `register_file`. It consumes `data_out1`/`data_out2` as operands and produces the write-back triple (`wb_data`, `wb_addr`, `wb_we`) that drives `register_file`'s `data_in`/`addr_write`/`we`. It handles the multi-cycle ops the single-cycle ALU does not: MUL, DIVU and REMU. The issuing controller stalls on `busy`.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_step.sv | 42 ++++
 rtl/muldiv_unit.sv | 138 +++++++++++++
 tb/tb_muldiv_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants for the iterative multiply/divide unit.
//   - op encodings (OP_MUL, OP_DIVU, OP_REMU; 2'b11 executes as MUL)
//   - FSM state constants (ST_IDLE, ST_RUN, ST_DONE)
//   - ITER: iterations per operation, DIV0_QUOT: quotient for divide by zero
//   - op_is_div(): true for the two division flavours
package muldiv_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int ITER      = WIDTH_DEF;

  localparam logic [WIDTH_DEF-1:0] DIV0_QUOT = '1;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REMU = 2'b10;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: combinational single-iteration datapath, MSB first.
//   is_div_i : 1 = restoring-division step, 0 = shift-add multiply step
//   md_i     : multiplicand (MUL) or divisor (DIV)
//   sh_i     : multiplier (MUL) or dividend-in/quotient-out shift register (DIV)
//   acc_i    : product accumulator (MUL) or partial remainder in low bits (DIV)
//   acc_o    : next accumulator
//   sh_o     : next shift register
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               is_div_i,
  input  logic [WIDTH-1:0]   md_i,
  input  logic [WIDTH-1:0]   sh_i,
  input  logic [2*WIDTH-1:0] acc_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0]   sh_o
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] rem_n;
  logic           qbit;

  always_comb begin
    // Bring the next dividend bit into the partial remainder; WIDTH+1 bits
    // so the trial value can exceed the divisor without overflowing.
    trial = {acc_i[WIDTH-1:0], sh_i[WIDTH-1]};
    qbit  = (trial >= {1'b0, md_i});
    rem_n = qbit ? (trial - {1'b0, md_i}) : trial;
    if (is_div_i) begin
      // A zero divisor always "fits", giving an all-ones quotient and the
      // dividend as remainder with no special casing.
      acc_o = {{(WIDTH-1){1'b0}}, rem_n};
      sh_o  = {sh_i[WIDTH-2:0], qbit};
    end else begin
      acc_o = (acc_i << 1) + (sh_i[WIDTH-1] ? {{WIDTH{1'b0}}, md_i} : '0);
      sh_o  = sh_i << 1;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 16-bit MUL / DIVU / REMU with register-file write-back.
//   clk, rst            : clock, synchronous active-high reset
//   start_i             : issue request, sampled only while idle
//   op_i, op_a_i,op_b_i : operation and unsigned operands
//   dest_i              : destination register
//   busy_o              : operation in flight (RUN or DONE)
//   done_o, wb_we_o     : one-cycle result-valid pulse
//   wb_data_o, wb_addr_o: result and destination, held until the next result
//   dbg_state_o         : current FSM state
//
// Handshake: a request is accepted on a rising edge where start_i=1 and
// busy_o=0; the issuer must hold request fields stable only for that edge.
// There is no back-pressure on the result: done_o/wb_we_o pulse once and
// the consumer must take the write-back in that cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [WIDTH-1:0]  op_a_i,
  input  logic [WIDTH-1:0]  op_b_i,
  input  logic [ADDR_W-1:0] dest_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [WIDTH-1:0]  wb_data_o,
  output logic [ADDR_W-1:0] wb_addr_o,
  output logic              wb_we_o,
  output logic [1:0]        dbg_state_o
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic [WIDTH-1:0]    md_q, md_d;
  logic [WIDTH-1:0]    sh_q, sh_d;
  logic [2*WIDTH-1:0]  acc_q, acc_d;
  logic [ADDR_W-1:0]   dest_q, dest_d;
  logic                done_q, done_d;
  logic [WIDTH-1:0]    wb_data_q, wb_data_d;
  logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;

  logic [2*WIDTH-1:0]  acc_n;
  logic [WIDTH-1:0]    sh_n;
  logic                last_iter;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (op_is_div(op_q)),
    .md_i     (md_q),
    .sh_i     (sh_q),
    .acc_i    (acc_q),
    .acc_o    (acc_n),
    .sh_o     (sh_n)
  );

  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    md_d      = md_q;
    sh_d      = sh_q;
    acc_d     = acc_q;
    dest_d    = dest_q;
    done_d    = 1'b0;
    wb_data_d = wb_data_q;
    wb_addr_d = wb_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          op_d    = op_i;
          md_d    = op_b_i;
          sh_d    = op_a_i;
          acc_d   = '0;
          cnt_d   = '0;
          dest_d  = dest_i;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = acc_n;
        sh_d  = sh_n;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) begin
          // Result is taken from the final step's outputs so it lands in
          // the write-back register on the same edge as the last iteration.
          state_d   = ST_DONE;
          done_d    = 1'b1;
          wb_data_d = (op_q == OP_DIVU) ? sh_n : acc_n[WIDTH-1:0];
          wb_addr_d = dest_q;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_MUL;
      md_q      <= '0;
      sh_q      <= '0;
      acc_q     <= '0;
      dest_q    <= '0;
      done_q    <= 1'b0;
      wb_data_q <= '0;
      wb_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      md_q      <= md_d;
      sh_q      <= sh_d;
      acc_q     <= acc_d;
      dest_q    <= dest_d;
      done_q    <= done_d;
      wb_data_q <= wb_data_d;
      wb_addr_q <= wb_addr_d;
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;
  assign wb_we_o     = done_q;
  assign wb_data_o   = wb_data_q;
  assign wb_addr_o   = wb_addr_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int W  = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  op_a = '0;
  logic [W-1:0]  op_b = '0;
  logic [AW-1:0] dest = '0;
  logic          busy, done, wb_we;
  logic [W-1:0]  wb_data;
  logic [AW-1:0] wb_addr;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [W-1:0]  exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int            exp_cyc_q[$];

  muldiv_unit #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .op_i        (op),
    .op_a_i      (op_a),
    .op_b_i      (op_b),
    .dest_i      (dest),
    .busy_o      (busy),
    .done_o      (done),
    .wb_data_o   (wb_data),
    .wb_addr_o   (wb_addr),
    .wb_we_o     (wb_we),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // reference model: plain unsigned arithmetic
  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [31:0] p;
    p = {16'h0, a} * {16'h0, b};
    case (o)
      2'b01:   return (b == 0) ? 16'hFFFF : a / b;
      2'b10:   return (b == 0) ? a : a % b;
      default: return p[15:0];
    endcase
  endfunction

  // Called at a negedge just before the edge that will accept the request.
  function automatic void push_exp(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [AW-1:0] d);
    exp_q.push_back(model(o, a, b));
    exp_addr_q.push_back(d);
    exp_cyc_q.push_back(cyc + 1 + 16);
  endfunction

  // driver
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input logic [AW-1:0] d);
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      chk("issue_timeout", 32'(busy), 32'd0);
    end else begin
      op = o; op_a = a; op_b = b; dest = d; start = 1'b1;
      push_exp(o, a, b, d);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_accept", 32'(busy), 32'd1);
      // operands are don't-care after the accept edge
      op = 2'($urandom); op_a = W'($urandom); op_b = W'($urandom); dest = AW'($urandom);
    end
  endtask

  // scoreboard monitor
  logic prev_we = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (wb_we || done) chk("done_eq_we", 32'(done), 32'(wb_we));
      if (wb_we) begin
        chk("we_one_cycle", 32'(prev_we), 32'd0);
        chk("busy_in_done", 32'(busy), 32'd1);
        if (exp_q.size() == 0) begin
          chk("unexpected_wb", 32'(wb_we), 32'd0);
        end else begin
          chk("wb_data", 32'(wb_data), 32'(exp_q.pop_front()));
          chk("wb_addr", 32'(wb_addr), 32'(exp_addr_q.pop_front()));
          chk("latency", cyc, exp_cyc_q.pop_front());
        end
      end
    end
    prev_we = wb_we;
  end

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] ra, rb;
    int n;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(wb_we), 32'd0);
    chk("rst_data", 32'(wb_data), 32'd0);
    chk("rst_addr", 32'(wb_addr), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // directed cases
    issue(2'b00, 16'd7, 16'd6, 3'd3);
    issue(2'b00, 16'd300, 16'd300, 3'd1);
    issue(2'b00, 16'hFFFF, 16'hFFFF, 3'd2);
    issue(2'b01, 16'd100, 16'd7, 3'd4);
    issue(2'b10, 16'd100, 16'd7, 3'd5);
    issue(2'b01, 16'hFFFF, 16'd1, 3'd6);
    issue(2'b01, 16'd1234, 16'd0, 3'd7);
    issue(2'b10, 16'd1234, 16'd0, 3'd0);
    issue(2'b11, 16'd123, 16'd45, 3'd2);

    // start held high: accepts at E0, E18, E36 only
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    for (int k = 0; k < 54; k++) begin
      op = 2'($urandom); op_a = W'($urandom); op_b = W'($urandom_range(0, 300)); dest = AW'($urandom);
      start = 1'b1;
      if (k % 18 == 0) push_exp(op, op_a, op_b, dest);
      @(posedge clk);
      @(negedge clk);
      chk("held_busy", 32'(busy), 32'((k % 18) != 17));
    end
    start = 1'b0;

    // reset in the middle of RUN abandons the operation
    issue(2'b00, 16'd55, 16'd77, 3'd3);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    void'(exp_q.pop_back());
    void'(exp_addr_q.pop_back());
    void'(exp_cyc_q.pop_back());
    @(posedge clk);
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_we", 32'(wb_we), 32'd0);
    chk("midrst_data", 32'(wb_data), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("no_wb_after_rst", 32'(wb_we), 32'd0);
    end
    issue(2'b01, 16'd5000, 16'd37, 3'd4);

    // randomized ops
    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 255));
        default: rb = W'($urandom);
      endcase
      issue(ro, ra, rb, AW'($urandom_range(0, 7)));
    end

    // drain
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
